// File: rtl/stream_arbiter_reg_n_inp3.sv
// stream_arbiter_reg_n_inp3: merges three valid/ready streams into one
// through a single registered output stage.
// Configuration macro STREAM_ARB_RR_EN: when defined, the arbiter is
// round-robin with a 2-bit priority pointer. When undefined, it uses fixed
// priority (input 0 highest, input 2 lowest) and the pointer does not exist.
module stream_arbiter_reg_n_inp3 #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [2:0]              inp_valid_i,
  output logic [2:0]              inp_ready_o,
  input  logic [3*DATA_WIDTH-1:0] inp_data_i,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i,
  output logic [DATA_WIDTH-1:0]   oup_data_o,
  output logic [1:0]              oup_idx_o
);

  logic                  oup_valid_q, oup_valid_d;
  logic [DATA_WIDTH-1:0] oup_data_q, oup_data_d;
  logic [1:0]            oup_idx_q, oup_idx_d;

  logic [1:0]            grant_idx;
  logic                  grant_any;
  logic [2:0]            grant_oh;
  logic                  slot_free;
  logic                  accept;
  logic [DATA_WIDTH-1:0] grant_data;

`ifdef STREAM_ARB_RR_EN
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] ord0, ord1, ord2;

  // Round-robin search: visit inputs starting at the pointer, first valid wins
  always_comb begin
    ord0 = 2'd0;
    ord1 = 2'd1;
    ord2 = 2'd2;
    case (ptr_q)
      2'd1: begin ord0 = 2'd1; ord1 = 2'd2; ord2 = 2'd0; end
      2'd2: begin ord0 = 2'd2; ord1 = 2'd0; ord2 = 2'd1; end
      default: begin ord0 = 2'd0; ord1 = 2'd1; ord2 = 2'd2; end
    endcase
    if (inp_valid_i[ord0])      grant_idx = ord0;
    else if (inp_valid_i[ord1]) grant_idx = ord1;
    else                        grant_idx = ord2;
  end

  // Pointer moves past the granted input, only when a beat is accepted
  always_comb begin
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
    end
  end

  // Pointer register, cleared to input 0 on reset
  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= 2'd0;
    else       ptr_q <= ptr_d;
  end
`else
  // Fixed priority: lowest-numbered valid input wins
  always_comb begin
    if (inp_valid_i[0])      grant_idx = 2'd0;
    else if (inp_valid_i[1]) grant_idx = 2'd1;
    else                     grant_idx = 2'd2;
  end
`endif

  // Grant, ready fan-out and payload selection; nothing is granted during reset
  always_comb begin
    grant_any  = |inp_valid_i;
    grant_oh   = grant_any ? (3'b001 << grant_idx) : 3'b000;
    slot_free  = ~rst_i & (~oup_valid_q | oup_ready_i);
    inp_ready_o = grant_oh & {3{slot_free}};
    accept     = |(inp_valid_i & inp_ready_o);
    case (grant_idx)
      2'd1:    grant_data = inp_data_i[1*DATA_WIDTH +: DATA_WIDTH];
      2'd2:    grant_data = inp_data_i[2*DATA_WIDTH +: DATA_WIDTH];
      default: grant_data = inp_data_i[0 +: DATA_WIDTH];
    endcase
  end

  // Output register next state: load on accept, drain on output handshake
  always_comb begin
    oup_valid_d = oup_valid_q;
    oup_data_d  = oup_data_q;
    oup_idx_d   = oup_idx_q;
    if (accept) begin
      oup_valid_d = 1'b1;
      oup_data_d  = grant_data;
      oup_idx_d   = grant_idx;
    end else if (oup_ready_i) begin
      oup_valid_d = 1'b0;
    end
  end

  // Output register; reset discards any held beat
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      oup_valid_q <= 1'b0;
      oup_data_q  <= '0;
      oup_idx_q   <= 2'd0;
    end else begin
      oup_valid_q <= oup_valid_d;
      oup_data_q  <= oup_data_d;
      oup_idx_q   <= oup_idx_d;
    end
  end

  assign oup_valid_o = oup_valid_q;
  assign oup_data_o  = oup_data_q;
  assign oup_idx_o   = oup_idx_q;

endmodule

// File: tb/tb_stream_arbiter_reg_n_inp3.sv
// Testbench for stream_arbiter_reg_n_inp3: directed vector table, corner
// sequences and randomized traffic against a reference model.
module tb_stream_arbiter_reg_n_inp3;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [2:0]  inp_valid_i;
  logic [2:0]  inp_ready_o;
  logic [23:0] inp_data_i;
  logic        oup_valid_o;
  logic        oup_ready_i;
  logic [7:0]  oup_data_o;
  logic [1:0]  oup_idx_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    bit         rst;
    logic [2:0] valid;
    bit         ready;
    logic [7:0] d0, d1, d2;
    logic [2:0] exp_ready;
    bit         exp_ov;
    logic [7:0] exp_data;
    logic [1:0] exp_idx;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic [1:0] idx;
  } beat_t;

  vec_t  tbl[11];
  beat_t sb[$];

  bit         m_valid;
  logic [7:0] m_data;
  logic [1:0] m_idx;
  int         m_ptr;

  stream_arbiter_reg_n_inp3 #(.DATA_WIDTH(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .inp_valid_i(inp_valid_i),
    .inp_ready_o(inp_ready_o),
    .inp_data_i(inp_data_i),
    .oup_valid_o(oup_valid_o),
    .oup_ready_i(oup_ready_i),
    .oup_data_o(oup_data_o),
    .oup_idx_o(oup_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive inputs just after a rising edge, then wait to mid-cycle for sampling
  task automatic applyStimulus(input bit rst, input logic [2:0] valid, input bit ready,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    rst_i       = rst;
    inp_valid_i = valid;
    oup_ready_i = ready;
    inp_data_i  = {d2, d1, d0};
    @(negedge clk_i);
  endtask

  // Advance past the next rising edge so registered outputs can be sampled
  task automatic stepClock();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkRegs(input string name, input bit ov, input logic [7:0] data, input logic [1:0] idx);
    checkOutput({name, "_valid"}, 32'(oup_valid_o), 32'(ov));
    checkOutput({name, "_data"}, 32'(oup_data_o), 32'(data));
    checkOutput({name, "_idx"}, 32'(oup_idx_o), 32'(idx));
  endtask

  // Reference arbitration: which input would win given valids and pointer
  function automatic int modelGrant(logic [2:0] v, int ptr);
    if (v == 3'b000) return -1;
`ifdef STREAM_ARB_RR_EN
    for (int k = 0; k < 3; k++) begin
      if (v[(ptr + k) % 3]) return (ptr + k) % 3;
    end
`else
    for (int k = 0; k < 3; k++) begin
      if (v[k]) return k;
    end
`endif
    return -1;
  endfunction

  initial begin
    beat_t      b;
    int         g;
    logic [2:0] exp_ready;
    logic [7:0] dv[3];
    bit         r, rdy;
    logic [2:0] v;

    rst_i = 1'b1;
    inp_valid_i = 3'b000;
    oup_ready_i = 1'b0;
    inp_data_i = '0;
    #1;

    // rst valid rdy d0 d1 d2 | exp_ready ov data idx
    tbl[0]  = '{1, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 2'd0};
    tbl[1]  = '{0, 3'b010, 1, 8'h00, 8'hA5, 8'h00, 3'b010, 1, 8'hA5, 2'd1};
    tbl[2]  = '{0, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 1, 8'hA5, 2'd1};
    tbl[3]  = '{0, 3'b001, 0, 8'h3C, 8'h00, 8'h00, 3'b000, 1, 8'hA5, 2'd1};
    tbl[4]  = '{0, 3'b100, 1, 8'h00, 8'h00, 8'h77, 3'b100, 1, 8'h77, 2'd2};
    tbl[5]  = '{0, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h77, 2'd2};
    tbl[6]  = '{0, 3'b001, 0, 8'h11, 8'h00, 8'h00, 3'b001, 1, 8'h11, 2'd0};
    tbl[7]  = '{0, 3'b000, 1, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h11, 2'd0};
    tbl[8]  = '{1, 3'b010, 1, 8'h00, 8'h5A, 8'h00, 3'b000, 0, 8'h00, 2'd0};
    tbl[9]  = '{0, 3'b100, 0, 8'h00, 8'h00, 8'hC3, 3'b100, 1, 8'hC3, 2'd2};
    tbl[10] = '{1, 3'b000, 0, 8'h00, 8'h00, 8'h00, 3'b000, 0, 8'h00, 2'd0};

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].valid, tbl[i].ready, tbl[i].d0, tbl[i].d1, tbl[i].d2);
      checkOutput($sformatf("tbl%0d_ready", i), 32'(inp_ready_o), 32'(tbl[i].exp_ready));
      stepClock();
      checkRegs($sformatf("tbl%0d", i), tbl[i].exp_ov, tbl[i].exp_data, tbl[i].exp_idx);
    end

`ifdef STREAM_ARB_RR_EN
    // All inputs valid, downstream always ready: strict rotation, no bubble
    applyStimulus(1, 3'b000, 0, 8'h00, 8'h00, 8'h00);
    stepClock();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 3'b111, 1, 8'h10, 8'h21, 8'h32);
      checkOutput($sformatf("rr%0d_ready", i), 32'(inp_ready_o), 32'(3'b001 << (i % 3)));
      stepClock();
      checkRegs($sformatf("rr%0d", i), 1, 8'h10 + 8'(8'h11 * (i % 3)), 2'(i % 3));
    end
`else
    // Fixed priority: input 0 starves the others once it is valid
    applyStimulus(1, 3'b000, 0, 8'h00, 8'h00, 8'h00);
    stepClock();
    applyStimulus(0, 3'b110, 1, 8'h10, 8'h21, 8'h32);
    checkOutput("fp0_ready", 32'(inp_ready_o), 32'(3'b010));
    stepClock();
    checkRegs("fp0", 1, 8'h21, 2'd1);
    for (int i = 1; i < 3; i++) begin
      applyStimulus(0, 3'b111, 1, 8'h40 + 8'(i), 8'h21, 8'h32);
      checkOutput($sformatf("fp%0d_ready", i), 32'(inp_ready_o), 32'(3'b001));
      stepClock();
      checkRegs($sformatf("fp%0d", i), 1, 8'h40 + 8'(i), 2'd0);
    end
`endif

    // Backpressure: held beat stays stable, then same-cycle reload
    applyStimulus(1, 3'b000, 0, 8'h00, 8'h00, 8'h00);
    stepClock();
    applyStimulus(0, 3'b111, 1, 8'hB0, 8'hB1, 8'hB2);
    stepClock();
    checkRegs("bp_load", 1, 8'hB0, 2'd0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 3'b111, 0, 8'hE0, 8'hB1, 8'hB2);
      checkOutput($sformatf("bp%0d_ready", i), 32'(inp_ready_o), 32'(3'b000));
      stepClock();
      checkRegs($sformatf("bp%0d", i), 1, 8'hB0, 2'd0);
    end
    applyStimulus(0, 3'b111, 1, 8'hE0, 8'hB1, 8'hB2);
`ifdef STREAM_ARB_RR_EN
    checkOutput("bp_rel_ready", 32'(inp_ready_o), 32'(3'b010));
    stepClock();
    checkRegs("bp_rel", 1, 8'hB1, 2'd1);
`else
    checkOutput("bp_rel_ready", 32'(inp_ready_o), 32'(3'b001));
    stepClock();
    checkRegs("bp_rel", 1, 8'hE0, 2'd0);
`endif

    // Reset while a beat is stalled: beat dropped, pointer back to input 0
    applyStimulus(1, 3'b000, 0, 8'h00, 8'h00, 8'h00);
    stepClock();
    applyStimulus(0, 3'b001, 0, 8'h66, 8'h00, 8'h00);
    stepClock();
    checkRegs("rstmid_load", 1, 8'h66, 2'd0);
    applyStimulus(1, 3'b111, 0, 8'h01, 8'h02, 8'h03);
    checkOutput("rstmid_ready", 32'(inp_ready_o), 32'(3'b000));
    stepClock();
    checkRegs("rstmid", 0, 8'h00, 2'd0);
    applyStimulus(0, 3'b111, 1, 8'h01, 8'h02, 8'h03);
    checkOutput("rstrel_ready", 32'(inp_ready_o), 32'(3'b001));
    stepClock();
    checkRegs("rstrel", 1, 8'h01, 2'd0);

    // Randomized traffic against the reference model and an in-order scoreboard
    applyStimulus(1, 3'b000, 0, 8'h00, 8'h00, 8'h00);
    stepClock();
    m_valid = 0; m_data = 8'h00; m_idx = 2'd0; m_ptr = 0;
    sb.delete();
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 249) == 0);
      v   = 3'($urandom_range(0, 7));
      rdy = ($urandom_range(0, 9) < 7);
      for (int k = 0; k < 3; k++) dv[k] = 8'($urandom_range(0, 255));
      applyStimulus(r, v, rdy, dv[0], dv[1], dv[2]);

      g = modelGrant(v, m_ptr);
      exp_ready = (!r && g >= 0 && (!m_valid || rdy)) ? 3'(1 << g) : 3'b000;
      checkOutput("rand_ready", 32'(inp_ready_o), 32'(exp_ready));
      checkOutput("rand_onehot", 32'($countones(inp_ready_o) <= 1), 32'd1);

      if (r) begin
        sb.delete();
      end else begin
        if (oup_valid_o && oup_ready_i) begin
          if (sb.size() == 0) begin
            checkOutput("sb_empty", 32'd1, 32'd0);
          end else begin
            b = sb.pop_front();
            checkOutput("sb_data", 32'(oup_data_o), 32'(b.data));
            checkOutput("sb_idx", 32'(oup_idx_o), 32'(b.idx));
          end
        end
        for (int k = 0; k < 3; k++) begin
          if (inp_valid_i[k] && inp_ready_o[k]) begin
            b.data = dv[k];
            b.idx  = 2'(k);
            sb.push_back(b);
          end
        end
      end

      if (r) begin
        m_valid = 0; m_data = 8'h00; m_idx = 2'd0; m_ptr = 0;
      end else if (exp_ready != 3'b000) begin
        m_valid = 1; m_data = dv[g]; m_idx = 2'(g); m_ptr = (g + 1) % 3;
      end else if (rdy) begin
        m_valid = 0;
      end

      stepClock();
      checkRegs("rand", m_valid, m_data, m_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
